// File: rtl/arm_seq_mult.sv
// arm_seq_mult -- sequential radix-2 shift-add multiplier.
//
// Accepts one operand pair in IDLE, then performs exactly WIDTH shift-add
// steps in CALC, then presents the product in DONE until the consumer
// takes it.
//
// Parameters
//   WIDTH  operand width in bits (4..32)
//   SIGNED 0 = unsigned operands, 1 = two's-complement operands
//   TRUNC  number of low product columns dropped when ARM_TRUNC_EN is defined
//
// Optional feature macro: ARM_TRUNC_EN
//   When it is defined, partial-product bits in columns below TRUNC are
//   discarded before each accumulation. The result is an approximate,
//   lower-bound magnitude with P[TRUNC-1:0] = 0. Latency is unchanged.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand pair on A/B is valid
//   in_ready     block accepts an operand pair this cycle (IDLE)
//   A, B         multiplicand, multiplier (WIDTH bits)
//   out_valid    P holds a completed product (DONE)
//   out_ready    consumer takes P this cycle
//   P            product (2*WIDTH bits); holds the last product, or 0 after reset
//   busy         high in CALC and DONE
//   dbg_state_o  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a transfer occurs on a rising edge where valid && ready are
// both high. On the input side, in_ready depends only on the state. On the
// output side, P and out_valid hold stable until the transfer takes place.
module arm_seq_mult #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0,
  parameter int TRUNC  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic               neg_d;
  logic [2*WIDTH-1:0] pp_d;
  logic [2*WIDTH-1:0] acc_d;

  // Operand magnitudes are formed at accept. The magnitude of -2^(WIDTH-1)
  // is 2^(WIDTH-1), which still fits in WIDTH unsigned bits. That keeps
  // the most-negative square exact.
  always_comb begin
    mag_a_d = A;
    mag_b_d = B;
    neg_d   = 1'b0;
    if (SIGNED != 0) begin
      if (A[WIDTH-1]) mag_a_d = -A;
      if (B[WIDTH-1]) mag_b_d = -B;
      neg_d = A[WIDTH-1] ^ B[WIDTH-1];
    end
  end

`ifdef ARM_TRUNC_EN
  localparam logic [2*WIDTH-1:0] ONE        = 1;
  localparam logic [2*WIDTH-1:0] TRUNC_MASK = ~((ONE << TRUNC) - ONE);
`endif

  // One shift-add step. The multiplicand register is already shifted by
  // the current step index.
  always_comb begin
    pp_d = mplier_q[0] ? mcand_q : '0;
`ifdef ARM_TRUNC_EN
    pp_d = pp_d & TRUNC_MASK;
`else
    pp_d = pp_d;
`endif
    acc_d = acc_q + pp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // The final step loads P directly from the sum it is forming.
          // This puts out_valid exactly WIDTH edges after the accept.
          if (cnt_q == LAST_STEP) begin
            p_q         <= neg_q ? -acc_d : acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign P           = p_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arm_seq_mult.sv
// tb_arm_seq_mult -- directed and random checks for arm_seq_mult.
// An unsigned and a signed instance (WIDTH=16, TRUNC=8) share the same
// inputs. Both are checked against hand-computed products and a reference
// product function.
module tb_arm_seq_mult;

  localparam int W = 16;
  localparam int T = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;

  logic          u_in_ready, u_out_valid, u_busy;
  logic [2*W-1:0] u_p;
  logic [1:0]    u_state;
  logic          s_in_ready, s_out_valid, s_busy;
  logic [2*W-1:0] s_p;
  logic [1:0]    s_state;

  int n_checks = 0;
  int n_pass   = 0;
  int in_count = 0;
  int out_count = 0;

  logic [2*W-1:0] exp_q[$];

  arm_seq_mult #(.WIDTH(W), .SIGNED(0), .TRUNC(T)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .A(a_in), .B(b_in), .out_valid(u_out_valid), .out_ready(out_ready),
    .P(u_p), .busy(u_busy), .dbg_state_o(u_state)
  );

  arm_seq_mult #(.WIDTH(W), .SIGNED(1), .TRUNC(T)) s_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .A(a_in), .B(b_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .P(s_p), .busy(s_busy), .dbg_state_o(s_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference product. Magnitudes are multiplied, optionally truncated
  // column-wise, and then negated when the signs differ.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit sgn);
    logic [W-1:0]   ma, mb;
    logic [2*W-1:0] sum;
    logic [2*W-1:0] one;
    bit             neg;
    ma = a; mb = b; neg = 1'b0;
    if (sgn) begin
      if (a[W-1]) ma = -a;
      if (b[W-1]) mb = -b;
      neg = a[W-1] ^ b[W-1];
    end
`ifdef ARM_TRUNC_EN
    one = 1;
    sum = '0;
    for (int i = 0; i < W; i++)
      if (mb[i]) sum = sum + (({{W{1'b0}}, ma} << i) & ~((one << T) - one));
`else
    one = 0;
    sum = {{W{1'b0}}, ma} * {{W{1'b0}}, mb} + one;
`endif
    return neg ? -sum : sum;
  endfunction

  // Issues one pair and waits for both products. The task holds out_ready
  // low for `stall` cycles in DONE, checking that P stays stable and the
  // block stays busy. With `early` set, out_ready is already high before
  // out_valid rises. Entry and exit are both at posedge+1 with the block
  // idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                        input bit early, output logic [2*W-1:0] pu,
                        output logic [2*W-1:0] ps, output int lat);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = early;
    @(posedge clk); #1;
    in_count++;
    in_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);   // ignored outside accept
    lat = 0;
    while (!u_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    pu = u_p; ps = s_p;
    if (u_out_valid) out_count++;
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_p_stable", u_p, pu);
        check("stall_in_ready", {s_in_ready, u_in_ready}, 2'b00);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;   // DONE lasts one cycle
    end
    out_ready = 1'b0;
    check("post_handshake", {u_out_valid, u_in_ready, s_in_ready}, 3'b011);
  endtask

  logic [2*W-1:0] pu, ps, ea, eb;
  int lat;
  int seen;

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", {u_in_ready, s_in_ready}, 2'b11);
    check("reset_out_valid", {u_out_valid, s_out_valid}, 2'b00);
    check("reset_p", u_p, 32'h0);
    check("reset_busy", {u_busy, s_busy}, 2'b00);
    check("reset_state", u_state, 2'd0);

`ifndef ARM_TRUNC_EN
    // max unsigned square and its signed view (-1 * -1)
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, pu, ps, lat);
    check("ffff_latency", lat, 16);
    check("ffff_u", pu, 32'hFFFE0001);
    check("ffff_s", ps, 32'h00000001);

    // most-negative square
    run_op(16'h8000, 16'h8000, 0, 1'b0, pu, ps, lat);
    check("8000_u", pu, 32'h40000000);
    check("8000_s", ps, 32'h40000000);

    // mixed signs: -3 * 7
    run_op(16'hFFFD, 16'h0007, 0, 1'b1, pu, ps, lat);
    check("m3x7_u", pu, 32'h0006FFEB);
    check("m3x7_s", ps, 32'hFFFFFFEB);
    check("early_latency", lat, 16);

    // five-cycle stall in DONE
    run_op(16'h0123, 16'h0100, 5, 1'b0, pu, ps, lat);
    check("stall_u", pu, 32'h00012300);
    check("stall_s", ps, 32'h00012300);
    check("p_holds_in_idle", u_p, 32'h00012300);
`else
    run_op(16'h00FF, 16'h0001, 0, 1'b0, pu, ps, lat);
    check("trunc_ff_u", pu, 32'h0);
    check("trunc_ff_s", ps, 32'h0);
    check("trunc_latency", lat, 16);
    run_op(16'h0123, 16'h0100, 5, 1'b0, pu, ps, lat);
    check("trunc_123_u", pu, 32'h00012300);
    check("trunc_123_s", ps, 32'h00012300);
`endif

    // reset during the 8th CALC cycle aborts the operation
    a_in = 16'h0007; b_in = 16'h0009; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("mid_calc_busy", {u_busy, u_state}, {1'b1, 2'd1});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_p", {u_p, s_p}, 64'h0);
    check("abort_in_ready", {u_in_ready, s_in_ready}, 2'b11);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (u_out_valid || s_out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_op(16'd3, 16'd5, 0, 1'b0, pu, ps, lat);
    check("after_abort_latency", lat, 16);
`ifndef ARM_TRUNC_EN
    check("after_abort_u", pu, 32'd15);
`endif
    check("after_abort_s", ps, ref_mul(16'd3, 16'd5, 1'b1));

    // random back-to-back pairs with random stalls
    in_count = 0; out_count = 0;
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n == 0) begin ra = 16'h8000; rb = 16'h7FFF; end
      exp_q.push_back(ref_mul(ra, rb, 1'b0));
      exp_q.push_back(ref_mul(ra, rb, 1'b1));
      run_op(ra, rb, $urandom_range(0, 3), bit'($urandom_range(0, 1)), pu, ps, lat);
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check("rand_u", pu, ea);
      check("rand_s", ps, eb);
    end
    check("pair_count", out_count, in_count);
    check("pair_total", in_count, 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
